// File: rtl/ls_down_timer.sv
// Loadable down-counter with reload register, one-shot/periodic modes and
// active-low borrow chain. Ports: D/LDL load, CIL enable, MODE, Q/QL/COL/TC/RUN.
module ls_down_timer #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RSTL,
  input  logic [WIDTH-1:0] D,
  input  logic             LDL,
  input  logic             CIL,
  input  logic             MODE,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] QL,
  output logic             COL,
  output logic             TC,
  output logic             RUN
);

  logic [WIDTH-1:0] rld;
  logic [WIDTH-1:0] q_nx;
  logic [WIDTH-1:0] rld_nx;
  logic             run_nx;
  logic             tc_nx;

  logic zero;
  logic ld;
  logic dec;
  logic term;

  assign zero = (Q == '0);
  assign ld   = ~LDL;
  assign dec  = LDL & ~CIL & RUN & ~zero;
  assign term = LDL & ~CIL & RUN & zero;

  // Borrow only when a terminal event is pending; load is ignored here
  assign COL = ~(~CIL & RUN & zero);
  assign QL  = ~Q;

  always_comb begin
    q_nx   = Q;
    rld_nx = rld;
    run_nx = RUN;
    tc_nx  = 1'b0;
    unique case (1'b1)
      ld: begin
        q_nx   = D;
        rld_nx = D;
        run_nx = 1'b1;
      end
      dec: begin
        q_nx = Q - WIDTH'(1);
      end
      term: begin
        tc_nx = 1'b1;
        if (MODE) begin
          q_nx = rld;
        end else begin
          run_nx = 1'b0;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RSTL) begin
    if (!RSTL) begin
      Q   <= '0;
      rld <= '0;
      RUN <= 1'b0;
      TC  <= 1'b0;
    end else begin
      Q   <= q_nx;
      rld <= rld_nx;
      RUN <= run_nx;
      TC  <= tc_nx;
    end
  end

endmodule
